// File: rtl/pdh_pkg.sv
// pdh_pkg: command-word layout, command codes and field widths shared by
// the PDH control core. The optional ADC readback (PDH_ADC_READBACK_EN)
// uses CMD_GET_ADC; without it that code decodes as unknown.
package pdh_pkg;

  localparam int RST_BIT     = 31;
  localparam int STROBE_BIT  = 30;
  localparam int CMD_MSB     = 29;
  localparam int CMD_LSB     = 26;
  localparam int CMD_W       = CMD_MSB - CMD_LSB + 1;
  localparam int DATA_W      = 26;
  localparam int DAC_SEL_BIT = 14;
  localparam int DAC_W       = 14;
  localparam int LED_W       = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE    = 4'h0,
    CMD_SET_LED = 4'h1,
    CMD_SET_DAC = 4'h2,
    CMD_GET_ADC = 4'h3
  } cmd_t;

  typedef struct packed {
    logic              soft_rst;
    logic              strobe;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

endpackage

// File: rtl/pdh_strobe_edge.sv
// pdh_strobe_edge: registers the PS command word once and produces a
// single-cycle execute pulse on each strobe rising edge, suppressed while
// the registered soft-reset bit is high.
module pdh_strobe_edge import pdh_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       word,
  output logic              exec,
  output logic              soft_rst,
  output logic              strobe,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] data
);

  cmd_word_t r1;
  cmd_word_t r1_next;
  logic      strobe_prev;

  assign r1_next = '{soft_rst: word[RST_BIT],
                     strobe:   word[STROBE_BIT],
                     cmd:      word[CMD_MSB:CMD_LSB],
                     data:     word[DATA_W-1:0]};

  // Input capture keeps sampling during soft reset so the reset can be
  // released; strobe_prev tracks r1.strobe so a strobe held high across
  // the soft-reset release is not seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1          <= '0;
      strobe_prev <= 1'b0;
    end else begin
      r1          <= r1_next;
      strobe_prev <= r1.strobe;
    end
  end

  assign exec     = r1.strobe & ~strobe_prev & ~r1.soft_rst;
  assign soft_rst = r1.soft_rst;
  assign strobe   = r1.strobe;
  assign cmd      = r1.cmd;
  assign data     = r1.data;

endmodule

// File: rtl/pdh_core.sv
// pdh_core: PS-facing control core of the PDH controller. Executes LED and
// DAC commands on strobe rising edges and returns a callback word.
// Optional feature macro: PDH_ADC_READBACK_EN (ADC latch + CMD_GET_ADC).
module pdh_core import pdh_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adc_tdata_i,
  input  logic        adc_tvalid_i,
  input  logic [31:0] axi_from_ps_i,
  output logic [31:0] axi_to_ps_o,
  output logic [7:0]  led_o,
  output logic [31:0] dac_tdata_o,
  output logic        dac_tvalid_o
);

  logic              exec;
  logic              soft_rst;
  logic              strobe;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;

  logic [DAC_W-1:0]  dac0;
  logic [DAC_W-1:0]  dac1;
  logic [CMD_W-1:0]  cb_cmd;
  logic              cb_strobe;
  logic [DATA_W-1:0] cb_data;

  pdh_strobe_edge u_strobe_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .word     (axi_from_ps_i),
    .exec     (exec),
    .soft_rst (soft_rst),
    .strobe   (strobe),
    .cmd      (cmd),
    .data     (data)
  );

`ifdef PDH_ADC_READBACK_EN
  logic [31:0]      adc_latched;
  logic [DAC_W-1:0] adc_sel;

  // Hold the most recent valid ADC sample for readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_latched <= '0;
    end else if (adc_tvalid_i) begin
      adc_latched <= adc_tdata_i;
    end
  end

  assign adc_sel = data[0] ? adc_latched[29:16] : adc_latched[13:0];
`else
  logic adc_unused;
  assign adc_unused = ^{adc_tdata_i, adc_tvalid_i};
`endif

  // Command execution, LED/DAC state and callback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o        <= '0;
      dac0         <= '0;
      dac1         <= '0;
      dac_tvalid_o <= 1'b0;
      cb_cmd       <= '0;
      cb_strobe    <= 1'b0;
      cb_data      <= '0;
    end else if (soft_rst) begin
      led_o        <= '0;
      dac0         <= '0;
      dac1         <= '0;
      dac_tvalid_o <= 1'b0;
      cb_cmd       <= '0;
      cb_strobe    <= 1'b0;
      cb_data      <= '0;
    end else begin
      dac_tvalid_o <= 1'b0;
      cb_strobe    <= strobe;
      if (exec) begin
        case (cmd)
          CMD_IDLE: begin
          end
          CMD_SET_LED: begin
            led_o   <= data[LED_W-1:0];
            cb_cmd  <= cmd;
            cb_data <= data;
          end
          CMD_SET_DAC: begin
            if (data[DAC_SEL_BIT]) begin
              dac1 <= data[DAC_W-1:0];
            end else begin
              dac0 <= data[DAC_W-1:0];
            end
            dac_tvalid_o <= 1'b1;
            cb_cmd       <= cmd;
            cb_data      <= data;
          end
`ifdef PDH_ADC_READBACK_EN
          CMD_GET_ADC: begin
            cb_cmd  <= cmd;
            cb_data <= {{(DATA_W-DAC_W){1'b0}}, adc_sel};
          end
`endif
          default: begin
            cb_cmd  <= cmd;
            cb_data <= '0;
          end
        endcase
      end
    end
  end

  assign dac_tdata_o = {2'b00, dac1, 2'b00, dac0};
  assign axi_to_ps_o = {cb_cmd, cb_strobe, 1'b0, cb_data};

endmodule

// File: tb/tb_pdh_core.sv
// tb_pdh_core: randomized and directed stimulus for pdh_core, checked
// against a command-level reference model of the PS protocol.
module tb_pdh_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adc_tdata_i = '0;
  logic        adc_tvalid_i = 1'b0;
  logic [31:0] axi_from_ps_i = '0;
  logic [31:0] axi_to_ps_o;
  logic [7:0]  led_o;
  logic [31:0] dac_tdata_o;
  logic        dac_tvalid_o;

`ifdef PDH_ADC_READBACK_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  pdh_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adc_tdata_i   (adc_tdata_i),
    .adc_tvalid_i  (adc_tvalid_i),
    .axi_from_ps_i (axi_from_ps_i),
    .axi_to_ps_o   (axi_to_ps_o),
    .led_o         (led_o),
    .dac_tdata_o   (dac_tdata_o),
    .dac_tvalid_o  (dac_tvalid_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  m_led   = '0;
  logic [13:0] m_dac0  = '0;
  logic [13:0] m_dac1  = '0;
  logic [3:0]  m_cmd   = '0;
  logic [25:0] m_data  = '0;
  logic        m_prev  = 1'b0;
  logic        m_soft  = 1'b0;
  logic        m_stb   = 1'b0;
  logic [31:0] m_adc   = '0;
  int          m_pulse_exp = 0;

  // DAC valid pulse monitor
  int          pulses  = 0;
  int          doubles = 0;
  logic        prev_v  = 1'b0;
  logic [31:0] tdata_at_pulse = '0;

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (dac_tvalid_o) begin
        pulses++;
        tdata_at_pulse = dac_tdata_o;
        if (prev_v) doubles++;
      end
      prev_v = dac_tvalid_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_dac();
    return {2'b00, m_dac1, 2'b00, m_dac0};
  endfunction

  function automatic logic [31:0] exp_cb();
    return m_soft ? 32'h0 : {m_cmd, m_stb, 1'b0, m_data};
  endfunction

  // Apply one PS word as the protocol defines it: act on a strobe rise.
  task automatic model_apply(input logic [31:0] w);
    logic [3:0]  c;
    logic [25:0] d;
    c = w[29:26];
    d = w[25:0];
    m_pulse_exp = 0;
    m_soft = w[31];
    m_stb  = w[30];
    if (w[31]) begin
      m_led = '0; m_dac0 = '0; m_dac1 = '0; m_cmd = '0; m_data = '0;
    end else if (w[30] && !m_prev) begin
      if (c == 4'h1) begin
        m_led = d[7:0]; m_cmd = c; m_data = d;
      end else if (c == 4'h2) begin
        if (d[14]) m_dac1 = d[13:0];
        else       m_dac0 = d[13:0];
        m_cmd = c; m_data = d; m_pulse_exp = 1;
      end else if (c == 4'h3 && ADC_EN) begin
        m_cmd  = c;
        m_data = {12'd0, d[0] ? m_adc[29:16] : m_adc[13:0]};
      end else if (c != 4'h0) begin
        m_cmd = c; m_data = '0;
      end
    end
    m_prev = w[30];
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"}, {24'd0, led_o}, {24'd0, m_led});
    check({tag, ".dac"}, dac_tdata_o, exp_dac());
    check({tag, ".cb"}, axi_to_ps_o, exp_cb());
    check({tag, ".tvalid"}, {31'd0, dac_tvalid_o}, 32'd0);
  endtask

  task automatic send(input string tag, input logic [31:0] w, input int hold);
    @(negedge clk);
    pulses = 0;
    axi_from_ps_i = w;
    model_apply(w);
    repeat (hold) @(negedge clk);
    check_all(tag);
    check({tag, ".pulses"}, pulses, m_pulse_exp);
    if (m_pulse_exp == 1) check({tag, ".pdata"}, tdata_at_pulse, exp_dac());
  endtask

  task automatic adc_pulse(input logic [31:0] v);
    @(negedge clk);
    adc_tdata_i  = v;
    adc_tvalid_i = 1'b1;
    m_adc = v;
    @(negedge clk);
    adc_tvalid_i = 1'b0;
    adc_tdata_i  = $urandom;
  endtask

  initial begin
    logic [31:0] w;

    // async reset
    repeat (3) @(negedge clk);
    check_all("rst");
    rst_n = 1'b1;

    // soft reset held for 10 cycles
    send("soft", 32'h8000_0000, 10);

    // SET_LED 0x55 with explicit 2-edge latency
    @(negedge clk);
    axi_from_ps_i = 32'h4400_0055;
    model_apply(32'h4400_0055);
    @(negedge clk);
    check("lat1", {24'd0, led_o}, 32'h0);
    @(negedge clk);
    check("lat2", {24'd0, led_o}, 32'h55);
    repeat (3) @(negedge clk);
    check_all("led_hi");
    send("led_hold", 32'h4400_00AA, 5);
    send("led_lo", 32'h0400_00AA, 5);
    check("cb55", axi_to_ps_o, 32'h1000_0055);

    // DAC channel writes
    send("dac0", 32'h4800_0123, 4);
    check("dac0v", dac_tdata_o, 32'h0000_0123);
    send("dac0l", 32'h0800_0123, 4);
    send("dac1", 32'h4800_5ABC, 4);
    check("dac1v", dac_tdata_o, 32'h1ABC_0123);
    send("dac1l", 32'h0800_5ABC, 4);
    send("dac0b", 32'h4800_0005, 4);
    check("dac0bv", dac_tdata_o, 32'h1ABC_0005);
    send("dac0bl", 32'h0800_0005, 4);

    // soft reset wins over a simultaneous strobe rise
    send("srst_stb", 32'hC400_0077, 4);
    check("srst_led", {24'd0, led_o}, 32'h0);
    send("srst_rel", 32'h4400_0077, 4);
    send("srst_lo", 32'h0400_0077, 4);

    // unknown command leaves LED/DAC alone
    send("pre_led", 32'h4400_003C, 4);
    send("pre_lo", 32'h0400_003C, 4);
    send("pre_dac", 32'h4800_4111, 4);
    send("pre_dlo", 32'h0800_4111, 4);
    send("unk", 32'h5C00_0123, 4);
    send("unk_lo", 32'h1C00_0123, 4);
    check("unk_cb", axi_to_ps_o, 32'h7000_0000);
    check("unk_led", {24'd0, led_o}, 32'h3C);

    // ADC readback (unknown command when the feature is off)
    adc_pulse(32'h2ABC_1234);
    send("adc1", 32'h4C00_0001, 4);
    send("adc1l", 32'h0C00_0001, 4);
    check("adc1cb", axi_to_ps_o, ADC_EN ? 32'h3000_2ABC : 32'h3000_0000);
    send("adc0", 32'h4C00_0000, 4);
    send("adc0l", 32'h0C00_0000, 4);
    check("adc0cb", axi_to_ps_o, ADC_EN ? 32'h3000_1234 : 32'h3000_0000);

    // randomized command stream
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) adc_pulse($urandom);
      w = $urandom;
      w[31] = ($urandom_range(0, 7) == 0);
      w[29:26] = 4'($urandom_range(0, 7));
      send("rnd", w, $urandom_range(3, 6));
    end

    check("tvalid_width", doubles, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
